key_schedule_store: RTL
=======================

// Module: key_schedule_store
// PURPOSE
//  Sequential AES-128 key schedule. Accepts a 128-bit cipher key on a start pulse and
//  iterates the combinational single-round expansion once per clock to produce round
//  keys 1..NR. Stores all NR+1 round keys and serves them to the cipher/inverse-cipher
//  datapath through an indexed, registered read port.
// PARAMETERS
//  NR      10   number of rounds; round keys 0..NR are stored (AES-128 only)
//  KEY_W   128  key / round-key width in bits
// PORTS
//  clk      in   1      single clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      1-cycle request: latch key_in and begin expansion
//  key_in   in   KEY_W  cipher key, sampled only on an accepted start
//  busy     out  1      expansion in progress
//  ready    out  1      all NR+1 round keys valid
//  rd_idx   in   4      round-key index to read (0..NR)
//  rd_key   out  KEY_W  registered round key for rd_idx
//  rd_valid out  1      registered: rd_key holds a valid stored key
// BEHAVIOUR
//  Reset (sync, rst=1 at an edge): state=IDLE; busy=0, ready=0, rd_key=0, rd_valid=0,
//   rnd=0, all rk[0..NR]=0. Reset wins over every other input, including mid-expansion.
//  FSM: IDLE, EXPAND, READY.
//   IDLE/READY: start=1 at edge E0 -> rk[0]<=key_in, rnd<=1, busy<=1, ready<=0, ->EXPAND.
//   EXPAND: each edge: rk[rnd] <= expand(rk[rnd-1], rnd); rnd<=rnd+1.
//    At the edge writing rk[NR] (E_NR): busy<=0, ready<=1, ->READY.
//   start while busy=1: ignored; key_in not sampled, expansion continues unchanged.
//   start in READY: restart as above; ready falls the cycle after E0, old keys overwritten.
//  Latency: busy visible the cycle after E0; ready visible the cycle after E10
//   (10 edges after start for NR=10). busy and ready are never both 1.
//  expand(w, r): w0..w3 = w[127:96..31:0]; t = SubWord(RotWord(w3)) ^ Rcon(r);
//   out = {t^w0, t^w0^w1, t^w0^w1^w2, t^w0^w1^w2^w3}. Rcon(r) = {rc[r],24'h0},
//   rc = 01,02,04,08,10,20,40,80,1b,36 for r=1..10. Round index is 4 bits, never wraps.
//  Read port (1-cycle latency): at every edge rd_key <= (ready && rd_idx<=NR) ?
//   rk[rd_idx] : 0; rd_valid <= ready && rd_idx<=NR. rd_idx>NR -> rd_key=0, rd_valid=0.
//   Reads while busy or in IDLE -> rd_valid=0, rd_key=0 (no partial keys leak).
//  rk[] written only by the FSM; no external write path.
// STRUCTURE
//  Shared package: NR, KEY_W, Rcon table, FSM state encoding (2-bit localparams).
//  One sub-module: key_round_expand (combinational expand(w, r); instantiates RotWord,
//   4x sbox, Rcon). Single instance, fed by rk[rnd-1] mux and rnd.
//  Top: FSM + 4-bit round counter + (NR+1)xKEY_W register array + registered read mux.
// TESTING
//  1 FIPS-197 A.1: key 2b7e151628aed2a6abf7158809cf4f3c, start -> ready after 10 edges;
//    rd_idx=1 -> a0fafe1788542cb123a339392a6c7605; rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
//  2 Zero key: rd_idx=1 -> 62636363626363636263636362636363;
//    rd_idx=10 -> b4ef5bcb3e92e21123e951cf6f8f188e; rd_idx=0 -> all zeros, rd_valid=1.
//  3 start pulsed again 3 cycles into expansion with a different key -> ignored; results
//    still match the first key; ready exactly 10 edges after the first start.
//  4 rst asserted at cycle 5 of expansion -> next cycle busy=0, ready=0, rd_valid=0;
//    new start then yields correct FIPS keys.
//  5 In READY, rd_idx=11 and 15 -> rd_valid=0, rd_key=0; rd_idx swept 10..0 back-to-back
//    -> correct key each cycle, 1-cycle latency.
//  6 Restart from READY with the FIPS key after the zero key -> ready=0 the cycle after
//    start, rd_valid=0 during busy, final keys equal FIPS set.

Source files
------------

// File: rtl/key_schedule_store_pkg.sv
// Shared constants, FSM encoding and byte-level AES helpers
// for the sequential AES-128 key schedule.
package key_schedule_store_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;

  localparam logic [3:0] NR_IDX = 4'(NR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] p;
    x = a;
    y = b;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b)
               : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b,
    input int         n
  );
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero)
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] s;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    s = r ^ rotl8(r, 1) ^ rotl8(r, 2)
      ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    return s;
  endfunction

endpackage

// File: rtl/key_schedule_store_round.sv
// Combinational single-round AES-128 key expansion:
// RotWord, four S-boxes, Rcon and the word xor chain.
module key_round_expand
  import key_schedule_store_pkg::*;
(
  input  logic [KEY_W-1:0] w,
  input  logic [3:0]       rnd,
  output logic [KEY_W-1:0] out
);

  logic [31:0] w0;
  logic [31:0] w1;
  logic [31:0] w2;
  logic [31:0] w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t;
  logic [31:0] o0;
  logic [31:0] o1;
  logic [31:0] o2;
  logic [31:0] o3;

  assign w0  = w[127:96];
  assign w1  = w[95:64];
  assign w2  = w[63:32];
  assign w3  = w[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sb
    assign sub[8*i +: 8] = sbox(rot[8*i +: 8]);
  end

  assign t  = sub ^ {rcon(rnd), 24'h0};
  assign o0 = t ^ w0;
  assign o1 = o0 ^ w1;
  assign o2 = o1 ^ w2;
  assign o3 = o2 ^ w3;
  assign out = {o0, o1, o2, o3};

endmodule

// File: rtl/key_schedule_store.sv
// Sequential AES-128 key schedule: one round per clock,
// all round keys stored, registered indexed read port.
module key_schedule_store
  import key_schedule_store_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             ready,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid
);

  state_t           state;
  state_t           state_nx;
  logic [3:0]       rnd;
  logic [KEY_W-1:0] rk [0:NR];
  logic [KEY_W-1:0] prev;
  logic [KEY_W-1:0] nxt;
  logic             load;
  logic             step;
  logic             last;
  logic             rd_ok;

  assign prev  = (rnd == 4'd0) ? rk[0] : rk[rnd - 4'd1];
  assign rd_ok = ready && (rd_idx <= NR_IDX);

  key_round_expand u_exp (
    .w   (prev),
    .rnd (rnd),
    .out (nxt)
  );

  // Next state: start accepted only outside EXPAND.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE, READY: begin
        if (start) begin
          load     = 1'b1;
          state_nx = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (rnd == NR_IDX) begin
          last     = 1'b1;
          state_nx = READY;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Round counter, key array and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      ready <= 1'b0;
      rnd   <= 4'd0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else if (load) begin
      rk[0] <= key_in;
      rnd   <= 4'd1;
      busy  <= 1'b1;
      ready <= 1'b0;
    end else if (step) begin
      rk[rnd] <= nxt;
      rnd     <= rnd + 4'd1;
      if (last) begin
        busy  <= 1'b0;
        ready <= 1'b1;
      end
    end
  end

  // Registered read port; nothing leaks unless ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      rd_key   <= rd_ok ? rk[rd_idx] : '0;
    end
  end

endmodule
